// File: rtl/vga_plot_arbiter_pkg.sv
// vga_plot_arbiter_pkg: shared VGA pixel-port widths, screen size and arbiter state encoding
package vga_plot_arbiter_pkg;
  localparam int VGA_X_W = 8;
  localparam int VGA_Y_W = 7;
  localparam int VGA_C_W = 3;
  localparam int VGA_W = 160;
  localparam int VGA_H = 120;
  typedef enum logic {ST_IDLE, ST_GRANT} state_t;
endpackage

// File: rtl/vga_plot_arbiter_prio_enc.sv
// plot_prio_enc: combinational lowest-index-set encoder
//  valid      in   N        request vector
//  idx        out  IW       index of the lowest set bit (0 when none set)
//  any_valid  out  1        at least one bit of valid is set
module plot_prio_enc #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  output logic [IW-1:0] idx,
  output logic          any_valid
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (valid[i]) idx = IW'(i);
  end
  assign any_valid = |valid;
endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the vga_adapter pixel-write port among N burst producers
//  clk, reset           clock, synchronous active-high reset
//  req_valid/req_last   per-requester pixel valid and end-of-burst flag
//  req_x/req_y/req_colour  packed per-requester pixel slices
//  req_ready            one-hot ready for the granted requester while in GRANT
//  vga_x/vga_y/vga_colour/vga_plot  registered pixel write, one cycle after accept
//  busy                 high while a burst is granted
//  grant_idx            current or most recent owner
//  burst_done           one-cycle pulse after a burst ends (last pixel or timeout)
module vga_plot_arbiter
  import vga_plot_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int TIMEOUT = 255,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req_valid,
  input  logic [N-1:0]           req_last,
  input  logic [N*VGA_X_W-1:0]   req_x,
  input  logic [N*VGA_Y_W-1:0]   req_y,
  input  logic [N*VGA_C_W-1:0]   req_colour,
  output logic [N-1:0]           req_ready,
  output logic [VGA_X_W-1:0]     vga_x,
  output logic [VGA_Y_W-1:0]     vga_y,
  output logic [VGA_C_W-1:0]     vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic [IW-1:0]          grant_idx,
  output logic                   burst_done
);
  state_t state, state_nx;
  logic [IW-1:0] enc_idx;
  logic any_valid, accept, last, timeout;
  logic [7:0] idle_cnt;
  plot_prio_enc #(.N(N)) u_enc (.valid(req_valid), .idx(enc_idx), .any_valid(any_valid));
  assign busy = state == ST_GRANT;
  // timeout fires on the no-accept cycle that brings the idle count up to TIMEOUT
  always_comb begin
    req_ready = '0;
    if (busy) req_ready[grant_idx] = 1'b1;
    accept = busy & req_valid[grant_idx];
    last = accept & req_last[grant_idx];
    timeout = busy & ~accept & (TIMEOUT != 0) & (({1'b0, idle_cnt} + 9'd1) >= 9'(TIMEOUT));
    state_nx = busy ? ((last | timeout) ? ST_IDLE : ST_GRANT) : (any_valid ? ST_GRANT : ST_IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_idx <= '0;
      idle_cnt <= '0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      vga_plot <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      vga_plot <= accept;
      burst_done <= last | timeout;
      if (accept) begin
        vga_x <= req_x[int'(grant_idx)*VGA_X_W +: VGA_X_W];
        vga_y <= req_y[int'(grant_idx)*VGA_Y_W +: VGA_Y_W];
        vga_colour <= req_colour[int'(grant_idx)*VGA_C_W +: VGA_C_W];
      end
      if (!busy && any_valid) grant_idx <= enc_idx;
      // cleared in IDLE so every burst starts with a fresh idle budget; saturates when TIMEOUT is 0
      idle_cnt <= (!busy || accept) ? '0 : ((idle_cnt == '1) ? idle_cnt : idle_cnt + 8'd1);
    end
  end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed and randomized checks of vga_plot_arbiter against a behavioural model
module tb_vga_plot_arbiter;
  localparam int N = 4;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req_valid, req_last, req_ready;
  logic [31:0] req_x;
  logic [27:0] req_y;
  logic [11:0] req_colour;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic vga_plot, busy, burst_done;
  logic [1:0] grant_idx;
  int n_checks = 0;
  int n_fail = 0;
  vga_plot_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_ready(req_ready),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .grant_idx(grant_idx), .burst_done(burst_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // behavioural model: owner is -1 when nobody holds the port
  int m_owner = -1;
  int m_idle = 0;
  logic [7:0] m_x = '0;
  logic [6:0] m_y = '0;
  logic [2:0] m_c = '0;
  logic m_plot = 1'b0, m_done = 1'b0;
  logic [1:0] m_gidx = '0;
  bit started = 1'b0;
  always @(posedge clk) begin
    started = 1'b1;
    if (reset) begin
      m_owner = -1; m_idle = 0; m_x = '0; m_y = '0; m_c = '0;
      m_plot = 1'b0; m_done = 1'b0; m_gidx = '0;
    end else if (m_owner < 0) begin
      m_plot = 1'b0;
      m_done = 1'b0;
      if (req_valid != 4'b0) begin
        for (int i = N - 1; i >= 0; i--) if (req_valid[i]) m_owner = i;
        m_gidx = 2'(m_owner);
        m_idle = 0;
      end
    end else if (req_valid[m_owner]) begin
      m_plot = 1'b1;
      m_x = req_x[8*m_owner +: 8];
      m_y = req_y[7*m_owner +: 7];
      m_c = req_colour[3*m_owner +: 3];
      m_idle = 0;
      m_done = req_last[m_owner];
      if (m_done) m_owner = -1;
    end else begin
      m_plot = 1'b0;
      m_idle++;
      m_done = (m_idle == TO);
      if (m_done) m_owner = -1;
    end
  end
  always @(negedge clk) begin
    if (started) begin
      chk("ready", req_ready, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("plot", vga_plot, m_plot);
      chk("x", vga_x, m_x);
      chk("y", vga_y, m_y);
      chk("colour", vga_colour, m_c);
      chk("busy", busy, m_owner >= 0);
      chk("grant_idx", grant_idx, m_gidx);
      chk("burst_done", burst_done, m_done);
    end
  end
  // grant order log: one entry each time busy rises
  int gseq [64];
  int gn = 0;
  logic pbusy = 1'b0;
  always @(negedge clk) begin
    if (busy === 1'b1 && pbusy !== 1'b1 && gn < 64) begin
      gseq[gn] = grant_idx;
      gn++;
    end
    pbusy = busy;
  end
  // per-requester pixel queues driven onto the bus; advance on accept
  logic [18:0] mem [4][64];
  int hd [4];
  int tl [4];
  int hold [4];
  logic [3:0] stall = '0;
  logic [3:0] acc;
  logic [18:0] drv_p;
  bit manual = 1'b1;
  always @(posedge clk) begin
    acc = req_valid & req_ready & {4{~reset}};
    #1;
    if (!manual) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) hd[i] = (hd[i] + 1) % 64;
        drv_p = mem[i][hd[i]];
        req_valid[i] = (hd[i] != tl[i]) && !stall[i];
        if (hd[i] != tl[i]) {req_x[8*i +: 8], req_y[7*i +: 7], req_colour[3*i +: 3]} = drv_p[17:0];
        req_last[i] = req_valid[i] ? drv_p[18] : 1'($urandom_range(0, 1));
      end
    end
  end
  task automatic push(input int i, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c, input logic l);
    mem[i][tl[i]] = {l, x, y, c};
    tl[i] = (tl[i] + 1) % 64;
  endtask
  task automatic push_burst(input int i, input int n, input int x0);
    for (int k = 0; k < n; k++) push(i, 8'(x0 + k), 7'(10 * i + k), 3'(k), k == n - 1);
  endtask
  task automatic clear_q();
    for (int i = 0; i < N; i++) hd[i] = tl[i];
  endtask
  function automatic bit q_empty();
    for (int i = 0; i < N; i++) if (hd[i] != tl[i]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic drive(input int i, input int x, input int y, input int c, input logic l);
    req_x[8*i +: 8] = 8'(x);
    req_y[7*i +: 7] = 7'(y);
    req_colour[3*i +: 3] = 3'(c);
    req_last[i] = l;
  endtask
  task automatic wait_plots(input int n, input string name);
    int seen = 0;
    for (int k = 0; k < 300 && seen < n; k++) begin
      @(negedge clk);
      if (vga_plot) seen++;
    end
    chk(name, seen, n);
  endtask
  task automatic wait_idle(input string name);
    for (int k = 0; k < 300 && !(busy == 1'b0 && q_empty() && req_valid == 4'b0); k++) @(negedge clk);
    chk(name, {busy, req_valid}, 0);
  endtask
  int base;
  logic [7:0] hx;
  logic [6:0] hy;
  initial begin
    reset = 1'b1; req_valid = 4'hf; req_last = '0; req_x = '0; req_y = '0; req_colour = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_plot", vga_plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outputs", {vga_x, vga_y, vga_colour, grant_idx, burst_done}, 0);
    req_valid = '0; reset = 1'b0;
    @(negedge clk);
    drive(2, 10, 20, 5, 1'b0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t2_gidx", grant_idx, 2);
    chk("t2_busy", busy, 1);
    chk("t2_ready", req_ready, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      drive(2, 10 + k, 20, 5, k == 2);
      @(negedge clk);
      chk("t2_plot", vga_plot, 1);
      chk("t2_x", vga_x, 10 + k);
      chk("t2_y", vga_y, 20);
      chk("t2_colour", vga_colour, 5);
      chk("t2_done", burst_done, k == 2);
    end
    req_valid = '0;
    @(negedge clk);
    chk("t2_done_once", burst_done, 0);
    chk("t2_plot_end", vga_plot, 0);
    chk("t2_gidx_hold", grant_idx, 2);
    manual = 1'b0;
    base = gn;
    push_burst(1, 3, 40);
    push_burst(3, 1, 90);
    for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
    chk("t3_first_grant", grant_idx, 1);
    push_burst(0, 2, 60);
    wait_idle("t3_idle");
    chk("t3_grants", gn - base, 3);
    chk("t3_order0", gseq[base], 1);
    chk("t3_order1", gseq[base+1], 0);
    chk("t3_order2", gseq[base+2], 3);
    base = gn;
    push_burst(2, 6, 100);
    wait_plots(2, "t4_start");
    stall[2] = 1'b1;
    @(negedge clk);
    hx = vga_x; hy = vga_y;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_plot", vga_plot, 0);
      chk("t4_xy_hold", {vga_x, vga_y}, {hx, hy});
      chk("t4_busy", busy, 1);
      chk("t4_gidx", grant_idx, 2);
      chk("t4_no_done", burst_done, 0);
      if (k == 3) stall[2] = 1'b0;
    end
    wait_idle("t4_idle");
    chk("t4_single_grant", gn - base, 1);
    manual = 1'b1;
    drive(3, 1, 1, 1, 1'b0);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("t5_gidx", grant_idx, 3);
    chk("t5_busy", busy, 1);
    drive(0, 7, 7, 2, 1'b1);
    req_valid = 4'b0001;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      chk("t5_done", burst_done, k == TO);
      chk("t5_busy_wait", busy, k != TO);
    end
    @(negedge clk);
    chk("t5_next_gidx", grant_idx, 0);
    chk("t5_next_busy", busy, 1);
    @(negedge clk);
    chk("t5_next_plot", {vga_plot, burst_done, vga_x}, {2'b11, 8'd7});
    req_valid = '0;
    @(negedge clk);
    manual = 1'b0;
    push_burst(1, 10, 150);
    wait_plots(3, "t6_start");
    manual = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_plot", vga_plot, 0);
    chk("t6_outputs", {vga_x, vga_y, vga_colour, grant_idx, burst_done, req_ready}, 0);
    req_valid = '0; reset = 1'b0;
    clear_q();
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_restart", {busy, vga_plot}, 0);
    end
    manual = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        if (hd[i] == tl[i] && $urandom_range(0, 15) == 0) begin
          int n = $urandom_range(1, 6);
          for (int k = 0; k < n; k++) push(i, 8'($urandom), 7'($urandom), 3'($urandom), k == n - 1);
        end
        if (hold[i] > 0) hold[i]--;
        else if ($urandom_range(0, 199) == 0) hold[i] = 12;
        stall[i] = (hold[i] > 0) || ($urandom_range(0, 4) == 0);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
